// File: rtl/riscv_pkg.sv
// Shared RV32I encodings for the load/store path: funct3 access types, access-size decode
// and write-back result-select codes.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SzByte = 2'b00,
    SzHalf = 2'b01,
    SzWord = 2'b10,
    SzNone = 2'b11
  } size_e;

  localparam logic [2:0] WB_ALU = 3'b001;
  localparam logic [2:0] WB_MEM = 3'b011;
  localparam logic [2:0] WB_PC4 = 3'b101;

  // Illegal encodings (011, 110, 111) decode to SzNone and suppress the access entirely.
  function automatic size_e decode_size(input logic [2:0] funct3);
    size_e sz;
    unique case (funct3)
      F3_B, F3_BU: sz = SzByte;
      F3_H, F3_HU: sz = SzHalf;
      F3_W:        sz = SzWord;
      default:     sz = SzNone;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load-data formatter: selects the addressed byte/halfword lane of a memory word and
// sign- or zero-extends it to 32 bits according to funct3.
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  byte_off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = word_i >> {byte_off_i, 3'b000};

  always_comb begin
    data_o = '0;
    unique case (funct3_i)
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    data_o = shifted;
      F3_BU:   data_o = {24'h0, shifted[7:0]};
      F3_HU:   data_o = {16'h0, shifted[15:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Word-organised data memory with integrated load/store unit for the single-cycle RV32I core.
// Stores commit at the clock edge; loads are combinational (read-before-write on collision).
module data_mem_lsu
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [2:0]  funct3,
  output logic [31:0] rd_data,
  output logic        misaligned,
  output logic        err_sticky,
  output logic [31:0] err_addr
);

  logic [31:0] mem_q [DEPTH];

  size_e       size;
  logic        legal;
  logic        store_en;
  logic [AW-1:0] word_idx;
  logic [31:0] rd_word;
  logic [31:0] ext_data;
  logic [3:0]  byte_en;
  logic [31:0] wr_lanes;
  logic [31:0] word_d;

  logic        err_sticky_q, err_sticky_d;
  logic [31:0] err_addr_q, err_addr_d;

  // Address bits above the memory range are ignored so accesses wrap.
  logic unused_addr;
  assign unused_addr = ^addr[31:AW+2];

  assign size     = decode_size(funct3);
  assign legal    = (size != SzNone);
  assign word_idx = addr[AW+1:2];
  assign rd_word  = mem_q[word_idx];

  assign misaligned = (mem_read | mem_write) & legal &
                      (((size == SzHalf) & addr[0]) |
                       ((size == SzWord) & (addr[1:0] != 2'b00)));

  assign store_en = mem_write & legal & ~misaligned;

  load_extend u_load_extend (
    .word_i    (rd_word),
    .byte_off_i(addr[1:0]),
    .funct3_i  (funct3),
    .data_o    (ext_data)
  );

  assign rd_data = (mem_read & legal & ~misaligned) ? ext_data : 32'h0;

  // Replicate the store data across lanes so each byte enable picks its own slice.
  always_comb begin
    byte_en  = 4'b0000;
    wr_lanes = wr_data;
    unique case (size)
      SzByte: begin
        byte_en  = 4'b0001 << addr[1:0];
        wr_lanes = {4{wr_data[7:0]}};
      end
      SzHalf: begin
        byte_en  = addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{wr_data[15:0]}};
      end
      SzWord: begin
        byte_en  = 4'b1111;
        wr_lanes = wr_data;
      end
      default: begin
        byte_en  = 4'b0000;
        wr_lanes = wr_data;
      end
    endcase
  end

  always_comb begin
    word_d = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) begin
        word_d[8*b +: 8] = wr_lanes[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (store_en) begin
      mem_q[word_idx] <= word_d;
    end
  end

  // Only the first misaligned access after reset is recorded.
  always_comb begin
    err_sticky_d = err_sticky_q;
    err_addr_d   = err_addr_q;
    if (misaligned && !err_sticky_q) begin
      err_sticky_d = 1'b1;
      err_addr_d   = addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
      err_addr_q   <= 32'h0;
    end else begin
      err_sticky_q <= err_sticky_d;
      err_addr_q   <= err_addr_d;
    end
  end

  assign err_sticky = err_sticky_q;
  assign err_addr   = err_addr_q;

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
- Word-organised data memory with an integrated load/store unit for the single-cycle RV32I core.
- Address comes from the ALU result. Store data comes from rs2.
- Produces the sign- or zero-extended load value that feeds the write-back result-select mux as the memory-data source (select code 3'b011).
- Stores commit on the rising clock edge. Loads are combinational, so a load completes in the same cycle.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two, ≥4.
- AW, $clog2(DEPTH), word-index width.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous active-high reset.
- addr  input  32  byte address (ALU result).
- wr_data  input  32  store data (rs2).
- mem_write  input  1  store enable.
- mem_read  input  1  load enable.
- funct3  input  3  access type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000 SB, 001 SH, 010 SW.
- rd_data  output  32  extended load result to the write-back mux.
- misaligned  output  1  current access is misaligned (combinational).
- err_sticky  output  1  latched misalignment flag.
- err_addr  output  32  address of the first misaligned access since reset.

Behaviour:
- Word index is addr[AW+1:2]. Upper address bits are ignored, so accesses wrap modulo DEPTH*4 bytes.
- misaligned = (mem_read|mem_write) & ((size==half & addr[0]) | (size==word & addr[1:0]!=0)).
  - size==half when funct3[1:0]==01.
  - size==word when funct3[1:0]==10.
- Illegal funct3 (011, 110, 111) is treated as no access: rd_data=0, no write, misaligned=0.
- Store, at posedge clk when mem_write & ~misaligned & ~rst:
  - SB writes wr_data[7:0] into byte lane addr[1:0].
  - SH writes wr_data[15:0] into halfword lane addr[1].
  - SW writes the full word.
  - Unselected lanes are preserved.
- Misaligned store: memory unchanged.
- Load (combinational):
  - Byte lane = word >> (8*addr[1:0]).
  - LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW passes the word.
- rd_data=0 when mem_read=0 or the load is misaligned. It never outputs X.
- Simultaneous mem_read & mem_write: the store commits at the edge, and rd_data shows pre-store contents during that cycle (read-before-write).
- Reset (synchronous, rst=1 at posedge):
  - All DEPTH words cleared to 0.
  - err_sticky←0, err_addr←0.
  - Any store in the same cycle is dropped.
  - rd_data reflects cleared memory from the next cycle.
- Error capture, at posedge with ~rst and misaligned:
  - If err_sticky==0: err_sticky←1 and err_addr←addr.
  - Later errors do not overwrite it. Only rst clears it.
- Reset values: rd_data=0 (memory zero), misaligned follows inputs, err_sticky=0, err_addr=0.
- Latency: store visible to a load in the next cycle. Load data is valid in the same cycle as the address.

Decomposition:
- Shared package riscv_pkg:
  - funct3 load/store encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - Size field decode constants.
  - Write-back select codes (WB_ALU=3'b001, WB_MEM=3'b011, WB_PC4=3'b101).
- One natural sub-module, load_extend: pure combinational lane select plus sign/zero extension (word, addr[1:0], funct3 → 32-bit).
- Byte-enable generation and storage stay in the top.

Test Plan:
- Reset then LW at 0x00, 0x04, 0xFC → rd_data=0x00000000 for each; err_sticky=0.
- SW 0x8899AABB @0x10; next cycle LW 0x10 → 0x8899AABB; LB 0x10 → 0xFFFFFFBB; LBU 0x13 → 0x00000088; LH 0x12 → 0xFFFF8899; LHU 0x10 → 0x0000AABB.
- Over that word, SB 0x5A @0x11 and SH 0x1234 @0x12 → LW 0x10 = 0x12345ABB.
- SW 0xDEADBEEF @0x21 → word 0x20 unchanged; misaligned=1 that cycle; err_sticky=1, err_addr=0x21. Then LH @0x23 → rd_data=0 and err_addr stays 0x21.
- Same cycle: mem_read & mem_write, SW 0xCAFEF00D @0x30 with old value 0x11111111 → rd_data=0x11111111 in that cycle, 0xCAFEF00D the next cycle.
- Address wrap: SW 0xA5A5A5A5 @ (DEPTH*4 + 0x8) → LW 0x8 = 0xA5A5A5A5. Then assert rst during a SW → store dropped, all reads 0, err_sticky=0.
